// File: rtl/phy_pkg.sv
// Shared PHY definitions: alignment symbol, RX FSM state encoding and
// the default COM run length. The TX serializer uses the same COM constant.
package phy_pkg;

    localparam logic [7:0] COM              = 8'hBC;
    localparam int         COM_LOCK_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/phy_rx_s2p_if.sv
// Serial-in / byte-out bundle of the RX serial-to-parallel front end.
// master drives the serial line and observes the rebuilt bytes; slave is the receiver.
interface phy_rx_s2p_if;

    logic       in_serial;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
    logic [1:0] state_out;

    modport master (
        output in_serial,
        input  data_out,
        input  valid_out,
        input  active_out,
        input  state_out
    );

    modport slave (
        input  in_serial,
        output data_out,
        output valid_out,
        output active_out,
        output state_out
    );

endinterface

// File: rtl/phy_rx_shift.sv
// Bit shifter and byte-phase counter of the RX front end.
// win is the byte ending at the bit currently on in_serial; boundary flags
// the last bit of a byte once the phase has been loaded by the FSM.
module phy_rx_shift (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       in_serial,
    input  logic       phase_load,
    output logic [7:0] win,
    output logic       boundary
);

    // Only the seven most recent bits matter: the eighth is the incoming bit
    // itself and the oldest bit would be shifted out without ever being looked at.
    logic [6:0] sr_reg;
    logic [2:0] bit_cnt_reg;

    assign win      = {sr_reg, in_serial};
    assign boundary = (bit_cnt_reg == 3'd7);

    // Shift one bit per cycle; the COM hit restarts the byte phase at 0.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
        end else begin
            sr_reg <= win[6:0];
            if (phase_load) begin
                bit_cnt_reg <= 3'd0;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

endmodule

// File: rtl/phy_rx_s2p.sv
// Serial-to-parallel RX front end: hunts for COM (0xBC) at bit level, locks
// after COM_LOCK consecutive aligned COMs and then delivers every non-COM byte.
// Optional feature macro: PHY_RX_LOL_EN (loss of lock after LOL_BYTES byte
// times without a COM); without it ACTIVE is left only by reset.
module phy_rx_s2p
    import phy_pkg::*;
#(
    parameter int COM_LOCK  = COM_LOCK_DEFAULT,
    parameter int LOL_BYTES = 255
) (
    input  logic         clk32f,
    input  logic         reset,
    phy_rx_s2p_if.slave  rx
);

    localparam logic [3:0] LOCK_N = COM_LOCK[3:0];
    localparam logic [7:0] LOL_N  = LOL_BYTES[7:0];

    if (COM_LOCK < 1 || COM_LOCK > 15) begin : g_bad_com_lock
        $error("phy_rx_s2p: COM_LOCK must be in 1..15");
    end
    if (LOL_BYTES < 1 || LOL_BYTES > 255) begin : g_bad_lol_bytes
        $error("phy_rx_s2p: LOL_BYTES must be in 1..255");
    end

    rx_state_t  state_reg;
    logic [3:0] com_cnt_reg;
    logic [7:0] data_reg;
    logic       valid_reg;
    logic       active_reg;
    logic [7:0] win;
    logic       boundary;
    logic       phase_load;
    logic       win_is_com;

`ifdef PHY_RX_LOL_EN
    logic [7:0] lol_cnt_reg;
`endif

    assign win_is_com = (win == COM);
    // Any COM seen during the bit-level hunt fixes the byte phase.
    assign phase_load = (state_reg == SEARCH) && win_is_com;

    phy_rx_shift u_shift (
        .clk32f     (clk32f),
        .reset      (reset),
        .in_serial  (rx.in_serial),
        .phase_load (phase_load),
        .win        (win),
        .boundary   (boundary)
    );

    assign rx.data_out   = data_reg;
    assign rx.valid_out  = valid_reg;
    assign rx.active_out = active_reg;
    assign rx.state_out  = state_reg;

    // Alignment FSM with COM run counter, optional loss-of-lock counter and registered outputs.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_reg   <= SEARCH;
            com_cnt_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            active_reg  <= 1'b0;
`ifdef PHY_RX_LOL_EN
            lol_cnt_reg <= '0;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                SEARCH: begin
                    if (win_is_com) begin
                        com_cnt_reg <= 4'd1;
                        if (LOCK_N == 4'd1) begin
                            state_reg  <= ACTIVE;
                            active_reg <= 1'b1;
                        end else begin
                            state_reg <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (win_is_com) begin
                            // Count never passes LOCK_N: reaching it leaves ALIGN.
                            com_cnt_reg <= com_cnt_reg + 4'd1;
                            if (com_cnt_reg + 4'd1 == LOCK_N) begin
                                state_reg  <= ACTIVE;
                                active_reg <= 1'b1;
                            end
                        end else begin
                            com_cnt_reg <= '0;
                            state_reg   <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
`ifdef PHY_RX_LOL_EN
                    // The byte that exhausted the budget was already delivered;
                    // drop lock one cycle later and restart the hunt.
                    if (lol_cnt_reg == LOL_N) begin
                        state_reg   <= SEARCH;
                        active_reg  <= 1'b0;
                        com_cnt_reg <= '0;
                        lol_cnt_reg <= '0;
                    end else if (boundary) begin
                        if (win_is_com) begin
                            lol_cnt_reg <= '0;
                        end else begin
                            data_reg    <= win;
                            valid_reg   <= 1'b1;
                            lol_cnt_reg <= lol_cnt_reg + 8'd1;
                        end
                    end
`else
                    if (boundary && !win_is_com) begin
                        data_reg  <= win;
                        valid_reg <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_reg <= SEARCH;
                end
            endcase
        end
    end

endmodule
